// File: rtl/bytewrite_ram_ctrl.sv
// bytewrite_ram_ctrl
//   Request/response front end for a single-port byte-write BRAM
//   (one-cycle read latency, read-first). Posted byte-masked writes run at
//   one per cycle. Reads are blocking and return data over a valid/ready
//   response channel. Optionally zero-fills the RAM after reset.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   req_valid_i/ready_o  request handshake (ready is a Moore output of state)
//   req_wr_i             1 = write, 0 = read
//   req_be_i             byte-lane write enables (writes only)
//   req_addr_i           word address (not range-checked)
//   req_wdata_i          write data
//   rsp_valid_o/ready_i  read response handshake
//   rsp_rdata_o          read data, held until the response is taken
//   clr_busy_o           high while the zero-fill sweep runs
//   ram_we_o/addr_o/di_o RAM port drive
//   ram_do_i             RAM read data, valid one edge after ram_addr_o is sampled
module bytewrite_ram_ctrl #(
    parameter int SIZE           = 1024,
    parameter int ADDR_WIDTH     = 10,
    parameter int COL_WIDTH      = 8,
    parameter int NB_COL         = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_wr_i,
    input  logic [NB_COL-1:0]             req_be_i,
    input  logic [ADDR_WIDTH-1:0]         req_addr_i,
    input  logic [NB_COL*COL_WIDTH-1:0]   req_wdata_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [NB_COL*COL_WIDTH-1:0]   rsp_rdata_o,
    output logic                          clr_busy_o,
    output logic [NB_COL-1:0]             ram_we_o,
    output logic [ADDR_WIDTH-1:0]         ram_addr_o,
    output logic [NB_COL*COL_WIDTH-1:0]   ram_di_o,
    input  logic [NB_COL*COL_WIDTH-1:0]   ram_do_i
);

    localparam int W = NB_COL * COL_WIDTH;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(SIZE - 1);

    state_t                 state_q,     state_d;
    logic [ADDR_WIDTH-1:0]  clr_cnt_q,   clr_cnt_d;
    logic [NB_COL-1:0]      ram_we_q,    ram_we_d;
    logic [ADDR_WIDTH-1:0]  ram_addr_q,  ram_addr_d;
    logic [W-1:0]           ram_di_q,    ram_di_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [W-1:0]           rsp_rdata_q, rsp_rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            clr_cnt_q   <= '0;
            ram_we_q    <= '0;
            ram_addr_q  <= '0;
            ram_di_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_di_q    <= ram_di_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_di_d    = ram_di_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            CLEAR: begin
                // The sweep drives the RAM port straight from clr_cnt_q (see
                // output muxing below), so the registered port stays quiet.
                clr_cnt_d = clr_cnt_q + 1'b1;
                ram_we_d  = '0;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                ram_we_d = '0;
                // In IDLE req_ready is high, so req_valid alone is an accept.
                if (req_valid_i) begin
                    ram_addr_d = req_addr_i;
                    if (req_wr_i) begin
                        ram_di_d = req_wdata_i;
                        ram_we_d = req_be_i;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                state_d = RD_DATA;
            end
            RD_DATA: begin
                rsp_rdata_d = ram_do_i;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // During the sweep the port is decoded from state so every CLEAR cycle
    // (including the first one out of reset) issues a full-word zero write.
    assign req_ready_o = (state_q == IDLE);
    assign clr_busy_o  = (state_q == CLEAR);
    assign ram_we_o    = (state_q == CLEAR) ? {NB_COL{1'b1}} : ram_we_q;
    assign ram_addr_o  = (state_q == CLEAR) ? clr_cnt_q      : ram_addr_q;
    assign ram_di_o    = (state_q == CLEAR) ? '0             : ram_di_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_bytewrite_ram_ctrl.sv
module tb_bytewrite_ram_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [3:0]  req_be;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        clr_busy;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_di;
    logic [31:0] ram_do;

    int checks;
    int failures;
    logic seed;

    bytewrite_ram_ctrl #(
        .SIZE(1024), .ADDR_WIDTH(10), .COL_WIDTH(8), .NB_COL(4), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
        .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .clr_busy_o(clr_busy), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_di_o(ram_di), .ram_do_i(ram_do)
    );

    // Behavioural byte-write BRAM: read-first, one-cycle latency.
    // While seed is high the array is filled with a non-zero pattern so the
    // zero-fill sweep has something visible to erase.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (seed) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5_0000 | i;
            ram_do <= 32'h0;
        end else begin
            ram_do <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_di[b*8 +: 8];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 3000) begin
            step();
            n++;
        end
        chk(tag, {31'b0, req_ready}, 32'h1);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        wait_ready("wr_ready");
        req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_be = be;
        step();
        req_valid = 1'b0;
    endtask

    // Issues a read (rsp_ready assumed high) and checks the two-edge latency,
    // the returned data and the return to IDLE after the handshake.
    task automatic do_read(input string tag, input logic [9:0] a, input logic [31:0] exp);
        wait_ready("rd_ready");
        req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
        step();                                   // E0: accepted
        req_valid = 1'b0;
        chk({tag, "_vld_e0"}, {31'b0, rsp_valid}, 32'h0);
        chk({tag, "_rdy_e0"}, {31'b0, req_ready}, 32'h0);
        step();                                   // E1
        chk({tag, "_vld_e1"}, {31'b0, rsp_valid}, 32'h0);
        step();                                   // E2
        chk({tag, "_vld_e2"}, {31'b0, rsp_valid}, 32'h1);
        chk({tag, "_data"}, rsp_rdata, exp);
        step();                                   // E3: response taken
        chk({tag, "_vld_e3"}, {31'b0, rsp_valid}, 32'h0);
        chk({tag, "_rdy_e3"}, {31'b0, req_ready}, 32'h1);
    endtask

    initial begin
        int n;
        int bad_we;
        int bad_addr;
        logic [31:0] held;

        checks = 0; failures = 0;
        seed = 1'b1; rst = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_be = 4'h0; req_addr = 10'h0; req_wdata = 32'h0;
        rsp_ready = 1'b1;

        // Reset state
        step(); step(); step();
        seed = 1'b0;
        chk("rst_clr_busy",  {31'b0, clr_busy},  32'h1);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_ram_addr",  {22'b0, ram_addr},  32'h0);

        // Zero-fill sweep: exactly 1024 cycles, full-word writes to 0..1023
        rst = 1'b0;
        n = 0; bad_we = 0; bad_addr = 0;
        while (clr_busy && n < 3000) begin
            if (ram_we !== 4'hF) bad_we++;
            if (ram_addr !== n[9:0]) bad_addr++;
            step();
            n++;
        end
        chk("sweep_len",    n, 1024);
        chk("sweep_we",     bad_we, 0);
        chk("sweep_addr",   bad_addr, 0);
        chk("sweep_ready",  {31'b0, req_ready}, 32'h1);

        do_read("clr_3ff", 10'h3FF, 32'h0000_0000);

        // Full write then read
        do_write(10'd5, 32'hDEADBEEF, 4'hF);
        do_read("full_5", 10'd5, 32'hDEADBEEF);

        // Partial write merges lanes 0 and 2
        do_write(10'd5, 32'h11223344, 4'b0101);
        do_read("part_5", 10'd5, 32'hDE22BE44);

        // Back-to-back writes, then a read of the last address next cycle
        wait_ready("b2b_ready");
        req_valid = 1'b1; req_wr = 1'b1; req_be = 4'hF;
        req_addr = 10'd0; req_wdata = 32'h0000_AAA0; step();
        chk("b2b_rdy0", {31'b0, req_ready}, 32'h1);
        req_addr = 10'd1; req_wdata = 32'h0000_AAA1; step();
        chk("b2b_rdy1", {31'b0, req_ready}, 32'h1);
        req_addr = 10'd2; req_wdata = 32'h0000_AAA2; step();
        chk("b2b_rdy2", {31'b0, req_ready}, 32'h1);
        do_read("b2b_rd2", 10'd2, 32'h0000_AAA2);
        do_read("b2b_rd0", 10'd0, 32'h0000_AAA0);

        // be = 0 write changes nothing
        do_write(10'd2, 32'hFFFF_FFFF, 4'h0);
        do_read("be0_2", 10'd2, 32'h0000_AAA2);

        // Response back-pressure for 7 cycles
        rsp_ready = 1'b0;
        wait_ready("stall_ready");
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'd1;
        step();
        req_valid = 1'b0;
        step(); step();
        chk("stall_vld", {31'b0, rsp_valid}, 32'h1);
        chk("stall_data", rsp_rdata, 32'h0000_AAA1);
        held = rsp_rdata;
        bad_we = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0) bad_we++;
        end
        chk("stall_stable", bad_we, 0);
        rsp_ready = 1'b1;
        step();
        chk("stall_rel_vld", {31'b0, rsp_valid}, 32'h0);
        chk("stall_rel_rdy", {31'b0, req_ready}, 32'h1);

        // Reset while in RD_DATA
        wait_ready("rrst_ready");
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'd5;
        step();                                   // E0 -> RD_ADDR
        req_valid = 1'b0;
        step();                                   // E1 -> RD_DATA
        rst = 1'b1;
        #1;
        chk("rrst_busy", {31'b0, clr_busy}, 32'h1);
        chk("rrst_vld",  {31'b0, rsp_valid}, 32'h0);
        chk("rrst_addr", {22'b0, ram_addr}, 32'h0);
        chk("rrst_rdy",  {31'b0, req_ready}, 32'h0);
        step();
        chk("rrst_vld2", {31'b0, rsp_valid}, 32'h0);
        rst = 1'b0;
        chk("rrst_addr0", {22'b0, ram_addr}, 32'h0);
        step();
        chk("rrst_addr1", {22'b0, ram_addr}, 32'h1);
        chk("rrst_vld3",  {31'b0, rsp_valid}, 32'h0);
        wait_ready("rrst_done");
        do_read("rrst_rd5", 10'd5, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
